param_receiver: RTL and testbench
=================================

PARAM_RECEIVER -- requirements
Module: param_receiver

Interface
REQ-001 SHALL have parameter OS_DIV, default 326, sysclk cycles per 16x-oversample tick (326 gives 9600 baud at 50 MHz); legal range 2..65535.
REQ-002 SHALL have parameter DATA_BITS, default 8, data bits per frame; legal range 5..9.
REQ-003 SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 even, 2 odd.
REQ-004 SHALL have parameter STOP_BITS, default 1, stop bits checked; legal values 1, 2.
REQ-005 SHALL have port sysclk, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port uart_rx, input, 1, asynchronous serial line, idle high.
REQ-008 SHALL have port rx_data, output, DATA_BITS, received word, LSB = first data bit.
REQ-009 SHALL have port rx_valid, output, 1, rx_data and error flags hold a word not yet consumed.
REQ-010 SHALL have port rx_ready, input, 1, consumer accepts word when high with rx_valid.
REQ-011 SHALL have port parity_err, output, 1, parity mismatch for the word in rx_data; 0 when PARITY=0.
REQ-012 SHALL have port frame_err, output, 1, any checked stop bit voted 0 for the word in rx_data.
REQ-013 SHALL have port overrun, output, 1, one-cycle pulse when a completed frame is dropped.
REQ-014 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-015 SHALL pass uart_rx through a two-flop synchronizer, preset to 1; all decisions use the synchronized value.
REQ-016 SHALL emit a one-cycle sample tick every OS_DIV sysclk cycles; tick counter SHALL restart at 0 on entering START, so phase aligns to the detected edge.
REQ-017 SHALL keep a 4-bit sample counter 0..15 per bit period, incremented per tick, wrapping 15->0 at bit boundary.
REQ-018 SHALL decide each bit by 2-of-3 majority of samples taken at counts 7, 8, 9.
REQ-019 SHALL implement states IDLE, START, DATA, PARITY, STOP.
REQ-020 IDLE->START on synchronized line 1->0 transition.
REQ-021 START: vote 1 at count 9 -> IDLE (false start, no output, no flags); vote 0 -> DATA at end of bit period.
REQ-022 DATA: shift DATA_BITS votes LSB first; after last bit -> PARITY if PARITY!=0, else STOP.
REQ-023 PARITY: parity_err candidate = vote XOR (XOR of data bits) for even, inverted for odd; -> STOP.
REQ-024 STOP: vote each of STOP_BITS bits; frame completes at count 9 of the final stop bit (no wait for bit end); -> IDLE.
REQ-025 On completion with stop vote 0, IDLE SHALL not re-arm until synchronized line has been 1 for one sysclk cycle (break does not restart).
REQ-026 Completion loads rx_data, parity_err, frame_err and sets rx_valid on the following sysclk edge.
REQ-027 rx_valid SHALL clear on the edge where rx_valid && rx_ready; outputs SHALL hold stable while rx_valid && !rx_ready.
REQ-028 Completion coinciding with rx_valid && rx_ready SHALL load the new word, keep rx_valid=1, no overrun.
REQ-029 Completion while rx_valid && !rx_ready SHALL keep the old word and pulse overrun for exactly one cycle.
REQ-030 Line glitches shorter than 2 of 3 votes SHALL not alter a decided bit.

Reset
REQ-031 On reset: state IDLE, counters 0, synchronizer 1, rx_data 0, rx_valid 0, parity_err 0, frame_err 0, overrun 0, busy 0.
REQ-032 Reset mid-frame SHALL abandon the frame with no output; the first frame after release SHALL need a fresh falling edge.

Structure
REQ-033 Shared package uart_pkg SHALL hold state encoding, parity-mode constants (PAR_NONE/EVEN/ODD) and sample positions 7/8/9.
REQ-034 Oversample tick generator SHALL be sub-module rx_sample_tick (params OS_DIV; ports sysclk, reset, restart, tick).

Verification (OS_DIV=4, one bit = 64 cycles)
REQ-035 8N1 frame 0xA5, rx_ready=1 -> rx_data=0xA5, rx_valid one cycle, no error flags.
REQ-036 DATA_BITS=7, PARITY=1, data 0x35 with parity bit 1 -> parity_err=1; parity bit 0 -> parity_err=0.
REQ-037 Low pulse of 20 cycles on idle line -> no rx_valid, busy returns 0 within 64 cycles.
REQ-038 Frame 0x3C with stop bit 0 -> rx_data=0x3C, frame_err=1; line held 0 for 200 further cycles -> no second frame.
REQ-039 Two frames 0x11, 0x22, rx_ready=0 -> rx_data stays 0x11, overrun pulses once; then rx_ready=1 -> rx_valid clears.
REQ-040 Reset asserted at data bit 3 of 0xFF, released, then frame 0x5A -> only 0x5A delivered.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: state encoding, parity modes and
// the oversample positions used for bit voting.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } rx_state_e;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_EVEN = 1;
    localparam int unsigned PAR_ODD  = 2;

    localparam logic [3:0] SAMPLE_FIRST = 4'd7;
    localparam logic [3:0] SAMPLE_MID   = 4'd8;
    localparam logic [3:0] SAMPLE_LAST  = 4'd9;
    localparam logic [3:0] SAMPLE_END   = 4'd15;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/rx_sample_tick.sv
// Oversample tick generator: one-cycle pulse every OS_DIV clocks, phase held
// at zero while restart is high so the first tick lands OS_DIV cycles later.
module rx_sample_tick #(
    parameter int unsigned OS_DIV = 326
) (
    input  logic sysclk,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int unsigned CntW = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(OS_DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (restart || (cnt_q == CntMax)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = !restart && (cnt_q == CntMax);

endmodule

// File: rtl/param_receiver.sv
// Parameterised UART receiver with 16x oversampling, 2-of-3 bit voting,
// optional parity, 1 or 2 stop bits and a valid/ready output holding register.
module param_receiver
    import uart_pkg::*;
#(
    parameter int unsigned OS_DIV    = 326,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                 sysclk,
    input  logic                 reset,
    input  logic                 uart_rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam logic [3:0] LastBit  = 4'(DATA_BITS - 1);
    localparam logic [3:0] LastStop = 4'(STOP_BITS - 1);

    logic [1:0]           sync_q;
    logic [1:0]           fill_q;
    logic                 rx_s;
    logic                 settled;
    logic                 armed_q, armed_d;
    rx_state_e            state_q, state_d;
    logic [3:0]           samp_cnt_q, samp_cnt_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic                 s_first_q, s_mid_q;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_err_q, par_err_d;
    logic                 stop_err_q, stop_err_d;
    logic                 tick;
    logic                 restart;
    logic                 at_first, at_mid, at_last, at_end;
    logic                 vote;
    logic                 complete;

    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;

    assign rx_s    = sync_q[1];
    // sync_q is preset high, so it only reflects the line once two real samples have shifted in.
    assign settled = fill_q[1];
    assign restart = (state_q == StIdle);

    rx_sample_tick #(
        .OS_DIV(OS_DIV)
    ) u_tick (
        .sysclk (sysclk),
        .reset  (reset),
        .restart(restart),
        .tick   (tick)
    );

    assign at_first = tick && (samp_cnt_q == SAMPLE_FIRST);
    assign at_mid   = tick && (samp_cnt_q == SAMPLE_MID);
    assign at_last  = tick && (samp_cnt_q == SAMPLE_LAST);
    assign at_end   = tick && (samp_cnt_q == SAMPLE_END);
    assign vote     = majority3(s_first_q, s_mid_q, rx_s);

    always_comb begin
        state_d    = state_q;
        samp_cnt_d = samp_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_err_d  = par_err_q;
        stop_err_d = stop_err_q;
        armed_d    = armed_q;
        complete   = 1'b0;

        if (tick) begin
            samp_cnt_d = samp_cnt_q + 4'd1;
        end

        unique case (state_q)
            StIdle: begin
                samp_cnt_d = '0;
                bit_cnt_d  = '0;
                par_err_d  = 1'b0;
                stop_err_d = 1'b0;
                // Re-arm only after seeing the line high, so a held break never restarts.
                if (settled && rx_s) begin
                    armed_d = 1'b1;
                end
                if (armed_q && !rx_s) begin
                    armed_d = 1'b0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (at_last && vote) begin
                    state_d = StIdle;
                end else if (at_end) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (at_last) begin
                    shift_d = {vote, shift_q[DATA_BITS-1:1]};
                end
                if (at_end) begin
                    if (bit_cnt_q == LastBit) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY != PAR_NONE) ? StParity : StStop;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            StParity: begin
                if (at_last) begin
                    case (PARITY)
                        PAR_EVEN: par_err_d = vote ^ (^shift_q);
                        PAR_ODD:  par_err_d = !(vote ^ (^shift_q));
                        default:  par_err_d = 1'b0;
                    endcase
                end
                if (at_end) begin
                    state_d = StStop;
                end
            end
            StStop: begin
                if (at_last) begin
                    if (!vote) begin
                        stop_err_d = 1'b1;
                    end
                    // The final stop bit completes mid-bit so back-to-back frames are not missed.
                    if (bit_cnt_q == LastStop) begin
                        complete = 1'b1;
                        state_d  = StIdle;
                    end
                end else if (at_end) begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        ovr_d   = 1'b0;
        if (complete) begin
            if (!valid_q || rx_ready) begin
                data_d  = shift_q;
                perr_d  = (PARITY != PAR_NONE) && par_err_q;
                ferr_d  = stop_err_q | !vote;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && rx_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            sync_q     <= 2'b11;
            fill_q     <= 2'b00;
            armed_q    <= 1'b0;
            state_q    <= StIdle;
            samp_cnt_q <= '0;
            bit_cnt_q  <= '0;
            s_first_q  <= 1'b1;
            s_mid_q    <= 1'b1;
            shift_q    <= '0;
            par_err_q  <= 1'b0;
            stop_err_q <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], uart_rx};
            fill_q     <= {fill_q[0], 1'b1};
            armed_q    <= armed_d;
            state_q    <= state_d;
            samp_cnt_q <= samp_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            if (at_first) begin
                s_first_q <= rx_s;
            end
            if (at_mid) begin
                s_mid_q <= rx_s;
            end
            shift_q    <= shift_d;
            par_err_q  <= par_err_d;
            stop_err_q <= stop_err_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            ovr_q      <= ovr_d;
        end
    end

    assign rx_data    = data_q;
    assign rx_valid   = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign overrun    = ovr_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_param_receiver.sv
// Self-checking bench for param_receiver: an 8N1 instance and a 7E1 instance,
// both at OS_DIV=4 (64 clocks per bit), checked against a frame-level model.
module tb_param_receiver;

    localparam int BitCyc = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic line_a = 1'b1, line_b = 1'b1;
    logic ready_a = 1'b1, ready_b = 1'b1;
    logic [7:0] data_a;
    logic [6:0] data_b;
    logic valid_a, perr_a, ferr_a, ovr_a, busy_a;
    logic valid_b, perr_b, ferr_b, ovr_b, busy_b;

    int checks = 0;
    int failures = 0;
    int valid_cycles_a = 0;
    int ovr_cnt_a = 0;
    int ovr_cnt_b = 0;
    logic [10:0] got_a[$];
    logic [10:0] got_b[$];

    always #5 clk = ~clk;

    param_receiver #(
        .OS_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)
    ) u_dut_a (
        .sysclk    (clk),
        .reset     (rst),
        .uart_rx   (line_a),
        .rx_data   (data_a),
        .rx_valid  (valid_a),
        .rx_ready  (ready_a),
        .parity_err(perr_a),
        .frame_err (ferr_a),
        .overrun   (ovr_a),
        .busy      (busy_a)
    );

    param_receiver #(
        .OS_DIV(4), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1)
    ) u_dut_b (
        .sysclk    (clk),
        .reset     (rst),
        .uart_rx   (line_b),
        .rx_data   (data_b),
        .rx_valid  (valid_b),
        .rx_ready  (ready_b),
        .parity_err(perr_b),
        .frame_err (ferr_b),
        .overrun   (ovr_b),
        .busy      (busy_b)
    );

    // Collect every accepted word as {frame_err, parity_err, data}.
    always @(negedge clk) begin
        if (valid_a) valid_cycles_a++;
        if (ovr_a) ovr_cnt_a++;
        if (ovr_b) ovr_cnt_b++;
        if (valid_a && ready_a) got_a.push_back({ferr_a, perr_a, 9'(data_a)});
        if (valid_b && ready_b) got_b.push_back({ferr_b, perr_b, 9'(data_b)});
    end

    // Frame-level reference: what a correct receiver reports for the bits sent.
    function automatic logic [10:0] model_word(input logic [8:0] data, input int nbits,
                                               input int pmode, input int pbit,
                                               input logic stop);
        logic [8:0] d;
        int ones;
        logic perr;
        d = data & ((9'h1 << nbits) - 9'h1);
        ones = $countones(d);
        if (pmode == 0) perr = 1'b0;
        else if (pmode == 1) perr = ((ones + pbit) % 2) != 0;
        else perr = ((ones + pbit) % 2) == 0;
        return {!stop, perr, d};
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(input int which, input logic v, input int glitch_at);
        for (int c = 0; c < BitCyc; c++) begin
            logic lv;
            lv = v;
            if (glitch_at >= 0 && (c == glitch_at || c == glitch_at + 1)) lv = ~v;
            if (which == 0) line_a = lv;
            else line_b = lv;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input int which, input logic [8:0] data, input int nbits,
                              input int pbit, input logic stop, input int glitch_bit);
        drive_bit(which, 1'b0, -1);
        for (int i = 0; i < nbits; i++) drive_bit(which, data[i], (i == glitch_bit) ? 36 : -1);
        if (pbit >= 0) drive_bit(which, pbit[0], -1);
        drive_bit(which, stop, -1);
        if (which == 0) line_a = 1'b1;
        else line_b = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(4);
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (data_a !== 8'h00) begin failures++; $display("FAIL reset_data_a got=%h want=00", data_a); end
        checks++; if (valid_a !== 1'b0) begin failures++; $display("FAIL reset_valid_a got=%b want=0", valid_a); end
        checks++; if (perr_a !== 1'b0 || ferr_a !== 1'b0) begin failures++; $display("FAIL reset_err_a got=%b%b want=00", perr_a, ferr_a); end
        checks++; if (ovr_a !== 1'b0) begin failures++; $display("FAIL reset_ovr_a got=%b want=0", ovr_a); end
        checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL reset_busy_a got=%b want=0", busy_a); end
        checks++; if (data_b !== 7'h00 || valid_b !== 1'b0 || busy_b !== 1'b0) begin
            failures++; $display("FAIL reset_b got data=%h valid=%b busy=%b want 00/0/0", data_b, valid_b, busy_b);
        end
        checks++; if (perr_b !== 1'b0 || ferr_b !== 1'b0 || ovr_b !== 1'b0) begin
            failures++; $display("FAIL reset_flags_b got=%b%b%b want=000", perr_b, ferr_b, ovr_b);
        end
    endtask

    task automatic test_basic();
        int vc0, ov0;
        logic [10:0] w, exp;
        got_a.delete();
        vc0 = valid_cycles_a;
        ov0 = ovr_cnt_a;
        exp = model_word(9'h0A5, 8, 0, -1, 1'b1);
        send_frame(0, 9'h0A5, 8, -1, 1'b1, -1);
        idle(10);
        checks++; if (valid_cycles_a - vc0 != 1) begin failures++; $display("FAIL basic_valid_cycles got=%0d want=1", valid_cycles_a - vc0); end
        checks++; if (ovr_cnt_a != ov0) begin failures++; $display("FAIL basic_overrun got=%0d want=0", ovr_cnt_a - ov0); end
        checks++;
        if (got_a.size() != 1) begin failures++; $display("FAIL basic_count got=%0d want=1", got_a.size()); end
        else begin
            w = got_a.pop_front();
            checks++; if (w !== exp) begin failures++; $display("FAIL basic_word got=%h want=%h", w, exp); end
        end
    endtask

    task automatic test_parity();
        logic [10:0] w, exp;
        for (int pb = 1; pb >= 0; pb--) begin
            got_b.delete();
            exp = model_word(9'h035, 7, 1, pb, 1'b1);
            send_frame(1, 9'h035, 7, pb, 1'b1, -1);
            idle(10);
            checks++;
            if (got_b.size() != 1) begin failures++; $display("FAIL parity_count pbit=%0d got=%0d want=1", pb, got_b.size()); end
            else begin
                w = got_b.pop_front();
                checks++; if (w !== exp) begin failures++; $display("FAIL parity_word pbit=%0d got=%h want=%h", pb, w, exp); end
            end
        end
    endtask

    task automatic test_random();
        logic [10:0] w, exp;
        logic [8:0] d;
        int g, pb;
        for (int n = 0; n < 6; n++) begin
            got_a.delete();
            d = 9'($urandom_range(0, 255));
            g = $urandom_range(0, 8) - 1;
            exp = model_word(d, 8, 0, -1, 1'b1);
            send_frame(0, d, 8, -1, 1'b1, g);
            idle(5);
            checks++;
            if (got_a.size() != 1) begin failures++; $display("FAIL rand_a_count n=%0d got=%0d want=1", n, got_a.size()); end
            else begin
                w = got_a.pop_front();
                checks++; if (w !== exp) begin failures++; $display("FAIL rand_a_word n=%0d glitch=%0d got=%h want=%h", n, g, w, exp); end
            end
        end
        for (int n = 0; n < 6; n++) begin
            got_b.delete();
            d = 9'($urandom_range(0, 127));
            pb = $urandom_range(0, 1);
            g = $urandom_range(0, 7) - 1;
            exp = model_word(d, 7, 1, pb, 1'b1);
            send_frame(1, d, 7, pb, 1'b1, g);
            idle(5);
            checks++;
            if (got_b.size() != 1) begin failures++; $display("FAIL rand_b_count n=%0d got=%0d want=1", n, got_b.size()); end
            else begin
                w = got_b.pop_front();
                checks++; if (w !== exp) begin failures++; $display("FAIL rand_b_word n=%0d got=%h want=%h", n, w, exp); end
            end
        end
    endtask

    task automatic test_false_start();
        bit seen_busy;
        int wait_cyc;
        got_a.delete();
        seen_busy = 0;
        line_a = 1'b0;
        for (int c = 0; c < 20; c++) begin
            idle(1);
            if (busy_a) seen_busy = 1;
        end
        line_a = 1'b1;
        wait_cyc = 0;
        while (busy_a && wait_cyc < 64) begin
            idle(1);
            wait_cyc++;
        end
        checks++; if (!seen_busy) begin failures++; $display("FAIL false_start_busy_seen got=0 want=1"); end
        checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL false_start_busy_clear got=%b want=0 after 64 cycles", busy_a); end
        idle(100);
        checks++; if (got_a.size() != 0) begin failures++; $display("FAIL false_start_words got=%0d want=0", got_a.size()); end
    endtask

    task automatic test_frame_err();
        logic [10:0] w, exp;
        got_a.delete();
        exp = model_word(9'h03C, 8, 0, -1, 1'b0);
        send_frame(0, 9'h03C, 8, -1, 1'b0, -1);
        line_a = 1'b0;
        idle(200);
        line_a = 1'b1;
        idle(200);
        checks++;
        if (got_a.size() != 1) begin failures++; $display("FAIL frame_err_count got=%0d want=1", got_a.size()); end
        else begin
            w = got_a.pop_front();
            checks++; if (w !== exp) begin failures++; $display("FAIL frame_err_word got=%h want=%h", w, exp); end
        end
        checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL frame_err_busy got=%b want=0", busy_a); end
    endtask

    task automatic test_overrun();
        int ov0;
        logic [10:0] w, exp;
        got_a.delete();
        ready_a = 1'b0;
        ov0 = ovr_cnt_a;
        exp = model_word(9'h011, 8, 0, -1, 1'b1);
        send_frame(0, 9'h011, 8, -1, 1'b1, -1);
        idle(20);
        send_frame(0, 9'h022, 8, -1, 1'b1, -1);
        idle(20);
        checks++; if (valid_a !== 1'b1) begin failures++; $display("FAIL overrun_valid got=%b want=1", valid_a); end
        checks++; if (data_a !== exp[7:0]) begin failures++; $display("FAIL overrun_data got=%h want=%h", data_a, exp[7:0]); end
        checks++; if (ovr_cnt_a - ov0 != 1) begin failures++; $display("FAIL overrun_pulses got=%0d want=1", ovr_cnt_a - ov0); end
        ready_a = 1'b1;
        idle(2);
        checks++; if (valid_a !== 1'b0) begin failures++; $display("FAIL overrun_clear got=%b want=0", valid_a); end
        checks++;
        if (got_a.size() != 1) begin failures++; $display("FAIL overrun_count got=%0d want=1", got_a.size()); end
        else begin
            w = got_a.pop_front();
            checks++; if (w !== exp) begin failures++; $display("FAIL overrun_word got=%h want=%h", w, exp); end
        end
    endtask

    task automatic test_back_to_back();
        logic [10:0] exp[$];
        logic [10:0] w;
        logic [8:0] d;
        got_a.delete();
        for (int n = 0; n < 3; n++) begin
            d = 9'($urandom_range(0, 255));
            exp.push_back(model_word(d, 8, 0, -1, 1'b1));
            send_frame(0, d, 8, -1, 1'b1, -1);
        end
        idle(10);
        checks++;
        if (got_a.size() != 3) begin failures++; $display("FAIL b2b_count got=%0d want=3", got_a.size()); end
        else begin
            for (int n = 0; n < 3; n++) begin
                w = got_a.pop_front();
                checks++; if (w !== exp[n]) begin failures++; $display("FAIL b2b_word n=%0d got=%h want=%h", n, w, exp[n]); end
            end
        end
    endtask

    task automatic test_reset_midframe();
        logic [10:0] w, exp;
        got_a.delete();
        drive_bit(0, 1'b0, -1);
        for (int i = 0; i < 3; i++) drive_bit(0, 1'b1, -1);
        idle(30);
        rst = 1'b1;
        idle(5);
        rst = 1'b0;
        idle(1);
        checks++; if (busy_a !== 1'b0 || valid_a !== 1'b0 || data_a !== 8'h00) begin
            failures++; $display("FAIL midreset_state got busy=%b valid=%b data=%h want 0/0/00", busy_a, valid_a, data_a);
        end
        idle(500);
        exp = model_word(9'h05A, 8, 0, -1, 1'b1);
        send_frame(0, 9'h05A, 8, -1, 1'b1, -1);
        idle(10);
        checks++;
        if (got_a.size() != 1) begin failures++; $display("FAIL midreset_count got=%0d want=1", got_a.size()); end
        else begin
            w = got_a.pop_front();
            checks++; if (w !== exp) begin failures++; $display("FAIL midreset_word got=%h want=%h", w, exp); end
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_parity();
        test_random();
        test_false_start();
        test_frame_err();
        test_overrun();
        test_back_to_back();
        test_reset_midframe();
        checks++; if (ovr_cnt_b != 0) begin failures++; $display("FAIL overrun_b got=%0d want=0", ovr_cnt_b); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
